// File: rtl/regfile_pkg.sv
// Shared register-file definitions: geometry, the zero register, the
// write-back request record and the requester index assignments.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // Requester slots on the write-back port
    localparam int WB_ALU    = 0;
    localparam int WB_LOAD   = 1;
    localparam int WB_MULDIV = 2;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Write-back grant logic. One-hot grant (or zero) chosen among req while en
// is high and rst is low.
// WB_ROUND_ROBIN_EN defined  : round-robin, ptr names the top-priority slot.
// WB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins, no ptr.
module wb_rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant
);

`ifdef WB_ROUND_ROBIN_EN

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]   N_EXT = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;

    // Search ptr, ptr+1, ... with wrap; first asserted request wins
    always_comb begin
        logic             found;
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; otherwise a latch is inferred.
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        if (en && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                sum = {1'b0, ptr} + (PTR_W+1)'(k);
                if (sum >= N_EXT) begin
                    sum = sum - N_EXT;
                end
                idx = sum[PTR_W-1:0];
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    ptr_next   = (idx == LAST) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    // Priority pointer advances past the winner; holds when nothing granted
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

`else

    // Fixed priority: the lowest asserted index wins
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        if (en && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && req[k]) begin
                    found    = 1'b1;
                    grant[k] = 1'b1;
                end
            end
        end
    end

    // No pointer state in this build; the clock is intentionally unused
    logic unused_clk;
    assign unused_clk = clk;

`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and sequencer for the register file's single write
// port. Accepts at most one requester per cycle, registers it, and drives
// rf_we/rf_waddr/rf_wdata one cycle later. Writes to the zero register are
// consumed without asserting rf_we.
// Optional feature macro: WB_ROUND_ROBIN_EN (round-robin instead of fixed
// priority arbitration).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata,
    output logic                      busy
);

    logic [NUM_REQ-1:0] grant;
    logic               en;
    logic               transfer;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               we_q;

    assign en = ~hold;

    wb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .en    (en),
        .grant (grant)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    // Route the granted requester's address and data to the output stage
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output register: capture on a transfer, otherwise drop the enable
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (transfer) begin
            we_q     <= (sel_addr != ADDR_W'(ZERO_REG));
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
        end else begin
            we_q     <= 1'b0;
        end
    end

    // A reset arriving while a write sits in the output stage discards it
    // before the register file can capture it at the next edge.
    assign rf_we = we_q & ~rst;

    assign busy = rf_we | (|req_valid);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter. Models the register
// file behind the write port (without its own zero guard) so that dropped
// and discarded writes are observable. Expected grant orders follow the
// WB_ROUND_ROBIN_EN build option.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = REG_ADDR_W;
    localparam int DW   = REG_DATA_W;

`ifdef WB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [DW-1:0]        rf_wdata;
    logic                 busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] rf_mem [NUM_REGS];

    regfile_wb_arbiter #(
        .NUM_REQ (NREQ),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: no zero guard, so a write to x0 would show up
    initial begin
        for (int r = 0; r < NUM_REGS; r++) rf_mem[r] = '0;
    end
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; req_valid = 3'b111;
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'(32'h100 + i));
        repeat (2) begin
            @(negedge clk); #1;
            n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b want 000", req_ready); end
            n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", rf_we); end
        end
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL reset_first_grant: got %b want 001", req_ready); end
        n_cmp++; if (rf_waddr !== '0 || rf_wdata !== '0) begin n_err++; $display("FAIL reset_outputs: got addr %0d data %h want 0/0", rf_waddr, rf_wdata); end
        req_valid = 3'b000; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_single();
        @(negedge clk);
        set_req(WB_LOAD, 5'd5, 32'h1234_5678);
        req_valid = 3'b010; #1;
        n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL single_ready: got %b want 010", req_ready); end
        @(negedge clk); req_valid = 3'b000; #1;
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
            n_err++; $display("FAIL single_write: got we %b addr %0d data %h want 1/5/12345678", rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk); #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL single_we_drop: got %b want 0", rf_we); end
        n_cmp++; if (rf_mem[5] !== 32'h1234_5678) begin n_err++; $display("FAIL single_rf: got %h want 12345678", rf_mem[5]); end
    endtask

    task automatic test_round_robin();
        wb_req_t       cur [NREQ];
        int            g, g_prev;
        logic [DW-1:0] prev_data;
        logic [AW-1:0] prev_addr;
        // Grant to requester 2 alone so the pointer starts at 0
        @(negedge clk);
        set_req(WB_MULDIV, 5'd30, 32'h0BAD_F00D);
        req_valid = 3'b100; #1;
        n_cmp++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL rr_prime: got %b want 100", req_ready); end
        for (int i = 0; i < NREQ; i++) begin
            cur[i].addr = AW'(8 + i);
            cur[i].data = DW'(32'hC000_0000 + i);
        end
        g_prev = 0; prev_data = '0; prev_addr = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k > 0) cur[g_prev].data = DW'(32'h5A00_0000 + (k << 4) + g_prev);
            for (int i = 0; i < NREQ; i++) set_req(i, cur[i].addr, cur[i].data);
            req_valid = 3'b111; #1;
            g = RR ? (k % NREQ) : 0;
            n_cmp++; if (req_ready !== NREQ'(1 << g)) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, NREQ'(1 << g)); end
            if (k > 0) begin
                n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== prev_addr || rf_wdata !== prev_data) begin
                    n_err++; $display("FAIL rr_write%0d: got we %b addr %0d data %h want 1/%0d/%h", k - 1, rf_we, rf_waddr, rf_wdata, prev_addr, prev_data);
                end
            end
            prev_data = cur[g].data; prev_addr = cur[g].addr; g_prev = g;
        end
        @(negedge clk); req_valid = 3'b000; #1;
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== prev_addr || rf_wdata !== prev_data) begin
            n_err++; $display("FAIL rr_write5: got we %b addr %0d data %h want 1/%0d/%h", rf_we, rf_waddr, rf_wdata, prev_addr, prev_data);
        end
        @(negedge clk); #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rr_we_drop: got %b want 0", rf_we); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        set_req(WB_ALU, ZERO_REG, 32'hFFFF_FFFF);
        req_valid = 3'b001; #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL zero_ready: got %b want 001", req_ready); end
        @(negedge clk); req_valid = 3'b000; #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL zero_we: got %b want 0", rf_we); end
        n_cmp++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL zero_capture: got addr %0d data %h want 0/ffffffff", rf_waddr, rf_wdata); end
        @(negedge clk); #1;
        n_cmp++; if (rf_mem[0] !== '0) begin n_err++; $display("FAIL zero_rf: got %h want 0", rf_mem[0]); end
    endtask

    task automatic test_hold();
        logic [DW-1:0] d [NREQ];
        int g1, g2;
        for (int i = 0; i < NREQ; i++) d[i] = DW'(32'hD000_0000 + i);
        g1 = RR ? 1 : 0;
        g2 = RR ? 2 : 0;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(20 + i), d[i]);
        req_valid = 3'b111; #1;
        n_cmp++; if (req_ready !== NREQ'(1 << g1)) begin n_err++; $display("FAIL hold_grant_t: got %b want %b", req_ready, NREQ'(1 << g1)); end
        @(negedge clk); hold = 1'b1; #1;
        n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL hold_ready1: got %b want 000", req_ready); end
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== AW'(20 + g1) || rf_wdata !== d[g1]) begin
            n_err++; $display("FAIL hold_inflight: got we %b addr %0d data %h want 1/%0d/%h", rf_we, rf_waddr, rf_wdata, 20 + g1, d[g1]);
        end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_busy: got %b want 1", busy); end
        @(negedge clk); #1;
        n_cmp++; if (req_ready !== 3'b000 || rf_we !== 1'b0) begin n_err++; $display("FAIL hold_ready2: got ready %b we %b want 000/0", req_ready, rf_we); end
        @(negedge clk); hold = 1'b0; #1;
        n_cmp++; if (req_ready !== NREQ'(1 << g2)) begin n_err++; $display("FAIL hold_resume: got %b want %b", req_ready, NREQ'(1 << g2)); end
        @(negedge clk); req_valid = 3'b000; #1;
        n_cmp++; if (rf_we !== 1'b1 || rf_wdata !== d[g2]) begin n_err++; $display("FAIL hold_resume_write: got we %b data %h want 1/%h", rf_we, rf_wdata, d[g2]); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_req(WB_ALU, 5'd7, 32'hDEAD_BEEF);
        req_valid = 3'b001; #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL rstmid_ready: got %b want 001", req_ready); end
        @(negedge clk); req_valid = 3'b000; rst = 1'b1; #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rstmid_we: got %b want 0", rf_we); end
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin
            n_err++; $display("FAIL rstmid_cleared: got we %b addr %0d data %h want 0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        n_cmp++; if (rf_mem[7] !== '0) begin n_err++; $display("FAIL rstmid_rf: got %h want 0", rf_mem[7]); end
        req_valid = 3'b111; #1;
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL rstmid_ptr: got %b want 001", req_ready); end
        req_valid = 3'b000;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_zero_reg();
        test_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
